// File: rtl/result_merge_stage.sv
// result_merge_stage
//
// Merges two per-lane result streams into one registered output stream.
// Each lane is buffered in a small FIFO. A round-robin arbiter pops the lane
// FIFO heads into a single output register and tags each beat with its
// source lane. When the lane FIFOs fill up, the resulting backpressure is
// returned upstream as per-lane stalls.
//
// Parameters
//   DATA_W   width of each result beat
//   DEPTH    entries per lane FIFO (power of two, >= 2)
//
// Ports
//   clk                      clock, rising edge
//   reset                    synchronous, active-high reset
//   in_valid_1/2             lane result valid
//   in_data_1/2              lane result data
//   in_flush_1/2             lane flush: empties the lane FIFO and drops the
//                            beat presented this cycle
//   out_stall_1/2            lane backpressure (lane FIFO full)
//   out_valid                merged beat valid
//   out_data                 merged beat data
//   out_src                  merged beat source: 0 = lane 1, 1 = lane 2
//   out_flush                registered OR of the lane flushes
//   in_stall                 downstream backpressure
//
// Build option
//   RESULT_MERGE_BYPASS_EN   when defined, a beat arriving at an empty lane
//                            may go straight into the output register in the
//                            cycle it arrives (latency 1). When undefined,
//                            every beat passes through its lane FIFO
//                            (latency 2).

module result_merge_stage #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid_1,
   input  logic [DATA_W-1:0] in_data_1,
   input  logic              in_flush_1,
   input  logic              in_valid_2,
   input  logic [DATA_W-1:0] in_data_2,
   input  logic              in_flush_2,
   output logic              out_stall_1,
   output logic              out_stall_2,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   output logic              out_flush,
   input  logic              in_stall
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Lane 1 FIFO state
   logic [DATA_W-1:0] mem_1 [DEPTH];
   logic [AW-1:0]     wr_ptr_1;
   logic [AW-1:0]     rd_ptr_1;
   logic [CW-1:0]     count_1;

   // Lane 2 FIFO state
   logic [DATA_W-1:0] mem_2 [DEPTH];
   logic [AW-1:0]     wr_ptr_2;
   logic [AW-1:0]     rd_ptr_2;
   logic [CW-1:0]     count_2;

   // Round-robin pointer: 0 prefers lane 1, 1 prefers lane 2
   logic rr;

   logic accept_1, accept_2;
   logic fifo_req_1, fifo_req_2;
   logic byp_req_1, byp_req_2;
   logic req_1, req_2;
   logic load;
   logic grant_1, grant_2;
   logic pop_1, pop_2;
   logic byp_1, byp_2;
   logic push_1, push_2;
   logic [DATA_W-1:0] head_1, head_2;
   logic [DATA_W-1:0] sel_data;
   logic              flush_hits_out;

   // Stall comes from the registered count only, so a full lane does not
   // accept even if its head leaves in the same cycle.
   assign out_stall_1 = (count_1 == FULL_CNT);
   assign out_stall_2 = (count_2 == FULL_CNT);

   assign accept_1 = in_valid_1 && !out_stall_1 && !in_flush_1;
   assign accept_2 = in_valid_2 && !out_stall_2 && !in_flush_2;

   assign fifo_req_1 = (count_1 != '0) && !in_flush_1;
   assign fifo_req_2 = (count_2 != '0) && !in_flush_2;

`ifdef RESULT_MERGE_BYPASS_EN
   // An empty lane can offer its incoming beat directly. A lane with buffered
   // beats only ever offers its FIFO head, which keeps the lane in order.
   assign byp_req_1 = (count_1 == '0) && in_valid_1 && !in_flush_1;
   assign byp_req_2 = (count_2 == '0) && in_valid_2 && !in_flush_2;
`else
   assign byp_req_1 = 1'b0;
   assign byp_req_2 = 1'b0;
`endif

   assign req_1 = fifo_req_1 || byp_req_1;
   assign req_2 = fifo_req_2 || byp_req_2;

   assign load = !out_valid || !in_stall;

   always_comb begin
      grant_1 = 1'b0;
      grant_2 = 1'b0;
      if (load) begin
         if (!rr) begin
            if (req_1)
               grant_1 = 1'b1;
            else if (req_2)
               grant_2 = 1'b1;
         end else begin
            if (req_2)
               grant_2 = 1'b1;
            else if (req_1)
               grant_1 = 1'b1;
         end
      end
   end

   // A granted lane either pops its FIFO head or, when empty, bypasses.
   assign pop_1 = grant_1 && fifo_req_1;
   assign pop_2 = grant_2 && fifo_req_2;
   assign byp_1 = grant_1 && !fifo_req_1;
   assign byp_2 = grant_2 && !fifo_req_2;

   // A bypassed beat is accepted but never written into the FIFO.
   assign push_1 = accept_1 && !byp_1;
   assign push_2 = accept_2 && !byp_2;

   assign head_1 = mem_1[rd_ptr_1];
   assign head_2 = mem_2[rd_ptr_2];

   always_comb begin
      sel_data = head_1;
      if (grant_2)
         sel_data = byp_2 ? in_data_2 : head_2;
      else if (grant_1)
         sel_data = byp_1 ? in_data_1 : head_1;
   end

   // A flush of the lane whose beat sits in the output register kills it,
   // even while downstream is stalling.
   assign flush_hits_out = out_valid &&
                           ((in_flush_1 && !out_src) || (in_flush_2 && out_src));

   // Lane 1 storage (data is not reset; count and pointers qualify it)
   always_ff @(posedge clk) begin
      if (push_1)
         mem_1[wr_ptr_1] <= in_data_1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_1 <= '0;
         rd_ptr_1 <= '0;
         count_1  <= '0;
      end else if (in_flush_1) begin
         wr_ptr_1 <= '0;
         rd_ptr_1 <= '0;
         count_1  <= '0;
      end else begin
         if (push_1)
            wr_ptr_1 <= wr_ptr_1 + AW'(1);
         if (pop_1)
            rd_ptr_1 <= rd_ptr_1 + AW'(1);
         count_1 <= count_1 + CW'(push_1) - CW'(pop_1);
      end
   end

   // Lane 2 storage
   always_ff @(posedge clk) begin
      if (push_2)
         mem_2[wr_ptr_2] <= in_data_2;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_2 <= '0;
         rd_ptr_2 <= '0;
         count_2  <= '0;
      end else if (in_flush_2) begin
         wr_ptr_2 <= '0;
         rd_ptr_2 <= '0;
         count_2  <= '0;
      end else begin
         if (push_2)
            wr_ptr_2 <= wr_ptr_2 + AW'(1);
         if (pop_2)
            rd_ptr_2 <= rd_ptr_2 + AW'(1);
         count_2 <= count_2 + CW'(push_2) - CW'(pop_2);
      end
   end

   // Output register, flush forwarding and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         out_flush <= 1'b0;
         rr        <= 1'b0;
      end else begin
         out_flush <= in_flush_1 || in_flush_2;
         if (load) begin
            out_valid <= grant_1 || grant_2;
            if (grant_1 || grant_2) begin
               out_data <= sel_data;
               out_src  <= grant_2;
               // the lane not granted becomes preferred
               rr       <= grant_1;
            end
         end else if (flush_hits_out) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
